// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Desc     : Shared sequencer state codes, widths and ALU opcodes.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam int unsigned ALU_DW = 3;
    localparam int unsigned ALU_RW = 4;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } seq_state_e;

    // Opcode map shared with the ALU decode so both sides agree.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_EQ  = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

endpackage

`default_nettype wire

// File: rtl/btn_pulse.sv
// +----------------------------------------------------------------------------+
// | Module   : btn_pulse                                                       |
// | Desc     : 2-flop synchronizer, optional debouncer (ALU_SEQ_DEBOUNCE_EN),  |
// |            registered rising-edge one-cycle pulse.                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic r_pulse;
    logic w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int unsigned c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_deb;

    // Level follows the synchronized input only after DEBOUNCE_CYCLES stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (r_sync2 != r_deb) begin
            if (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1)) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_pulse   <= w_level & ~r_level_d;
        end
    end

    assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_operand_sequencer                                           |
// | Desc     : Button-stepped loader of A, B, opcode; holds them for an exec   |
// |            window and captures the ALU result. Macro: ALU_SEQ_DEBOUNCE_EN. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DW              = ALU_DW,
    parameter int unsigned RW              = ALU_RW,
    parameter int unsigned EXEC_CYCLES     = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] sw,
    input  logic          btn_next,
    input  logic          btn_clear,
    input  logic [RW-1:0] alu_result,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [DW-1:0] op,
    output logic          alu_valid,
    output logic [RW-1:0] result,
    output logic          result_valid,
    output logic [2:0]    state_led
);

    localparam logic [3:0] c_exec_load = 4'(EXEC_CYCLES - 1);

    logic w_next_p;
    logic w_clear_p;

    seq_state_e    r_state, w_state_nxt;
    logic [DW-1:0] r_a, w_a_nxt;
    logic [DW-1:0] r_b, w_b_nxt;
    logic [DW-1:0] r_op, w_op_nxt;
    logic [RW-1:0] r_result, w_result_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_next),
        .pulse (w_next_p)
    );

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .pulse (w_clear_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_LOAD_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_result <= w_result_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_result_nxt = r_result;
        w_cnt_nxt    = r_cnt;

        // Clear overrides any same-cycle advance.
        if (w_clear_p) begin
            w_state_nxt  = ST_LOAD_A;
            w_a_nxt      = '0;
            w_b_nxt      = '0;
            w_op_nxt     = '0;
            w_result_nxt = '0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                ST_LOAD_A: if (w_next_p) begin
                    w_a_nxt     = sw;
                    w_state_nxt = ST_LOAD_B;
                end
                ST_LOAD_B: if (w_next_p) begin
                    w_b_nxt     = sw;
                    w_state_nxt = ST_LOAD_OP;
                end
                ST_LOAD_OP: if (w_next_p) begin
                    w_op_nxt    = sw;
                    w_cnt_nxt   = c_exec_load;
                    w_state_nxt = ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        w_result_nxt = alu_result;
                        w_state_nxt  = ST_SHOW;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                ST_SHOW: if (w_next_p) begin
                    w_state_nxt = ST_LOAD_A;
                end
                default: w_state_nxt = ST_LOAD_A;
            endcase
        end
    end

    assign a            = r_a;
    assign b            = r_b;
    assign op           = r_op;
    assign result       = r_result;
    assign alu_valid    = (r_state == ST_EXEC);
    assign result_valid = (r_state == ST_SHOW);
    assign state_led    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_operand_sequencer                                        |
// | Desc     : Randomized bench with transaction-level model; two DUTs with    |
// |            EXEC_CYCLES=1 and 4 share stimulus. Macro: ALU_SEQ_DEBOUNCE_EN. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_operand_sequencer;
    import alu_pkg::*;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int c_deb = 8;
`else
    localparam int c_deb = 0;
`endif
    localparam int c_deb_param = (c_deb == 0) ? 250000 : c_deb;
    localparam int c_lat = 3 + c_deb;   // button edge to pulse
    localparam int c_idle = c_deb + 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = 3'd0;
    logic       btn_next = 1'b0;
    logic       btn_clear = 1'b0;

    logic [2:0] a1, b1, op1, led1, a4, b4, op4, led4;
    logic [3:0] res1, res4, alu1, alu4;
    logic       av1, rv1, av4, rv4;

    int         m_state;
    logic [2:0] m_a, m_b, m_op;
    logic [3:0] m_res;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [2:0] x, input logic [2:0] y, input logic [2:0] o);
        int ix, iy;
        ix = int'(x);
        iy = int'(y);
        case (o)
            OP_ADD:  return 4'((ix + iy) & 15);
            OP_SUB:  return 4'((ix - iy) & 15);
            OP_AND:  return 4'(ix & iy);
            OP_OR:   return 4'(ix | iy);
            OP_XOR:  return 4'(ix ^ iy);
            OP_EQ:   return (ix == iy) ? 4'd1 : 4'd0;
            OP_LT:   return (ix < iy) ? 4'd1 : 4'd0;
            default: return 4'((~ix) & 7);
        endcase
    endfunction

    assign alu1 = alu_ref(a1, b1, op1);
    assign alu4 = alu_ref(a4, b4, op4);

    alu_operand_sequencer #(.EXEC_CYCLES(1), .DEBOUNCE_CYCLES(c_deb_param)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
        .alu_result(alu1), .a(a1), .b(b1), .op(op1), .alu_valid(av1),
        .result(res1), .result_valid(rv1), .state_led(led1)
    );

    alu_operand_sequencer #(.EXEC_CYCLES(4), .DEBOUNCE_CYCLES(c_deb_param)) dut4 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
        .alu_result(alu4), .a(a4), .b(b4), .op(op4), .alu_valid(av4),
        .result(res4), .result_valid(rv4), .state_led(led4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
    endtask

    // Settled effect of one button action; EXEC has always finished by check time.
    task automatic model_step(input bit nxt, input bit clr);
        if (clr) begin
            model_reset();
        end else if (nxt) begin
            case (m_state)
                0: begin m_a = sw; m_state = 1; end
                1: begin m_b = sw; m_state = 2; end
                2: begin m_op = sw; m_res = alu_ref(m_a, m_b, sw); m_state = 4; end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/led1"}, 32'(led1), 32'(m_state));
        chk({tag, "/led4"}, 32'(led4), 32'(m_state));
        chk({tag, "/a1"}, 32'(a1), 32'(m_a));
        chk({tag, "/a4"}, 32'(a4), 32'(m_a));
        chk({tag, "/b1"}, 32'(b1), 32'(m_b));
        chk({tag, "/b4"}, 32'(b4), 32'(m_b));
        chk({tag, "/op1"}, 32'(op1), 32'(m_op));
        chk({tag, "/op4"}, 32'(op4), 32'(m_op));
        chk({tag, "/res1"}, 32'(res1), 32'(m_res));
        chk({tag, "/res4"}, 32'(res4), 32'(m_res));
        chk({tag, "/av1"}, 32'(av1), 32'(m_state == 3));
        chk({tag, "/av4"}, 32'(av4), 32'(m_state == 3));
        chk({tag, "/rv1"}, 32'(rv1), 32'(m_state == 4));
        chk({tag, "/rv4"}, 32'(rv4), 32'(m_state == 4));
    endtask

    task automatic act(input bit nxt, input bit clr, input int hold);
        btn_next  = nxt;
        btn_clear = clr;
        cyc(hold);
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        cyc(c_idle);
        model_step(nxt, clr);
    endtask

    // Cycle-exact exec window check for both EXEC_CYCLES settings.
    task automatic timed_run(input logic [2:0] bv, input logic [3:0] exp_res);
        sw = 3'b101; act(1'b1, 1'b0, c_deb + 2);
        sw = bv;     act(1'b1, 1'b0, c_deb + 2);
        sw = OP_EQ;
        btn_next = 1'b1;
        for (int k = 1; k <= c_lat + 8; k++) begin
            cyc(1);
            chk("t_av1", 32'(av1), 32'(k >= c_lat + 1 && k <= c_lat + 1));
            chk("t_rv1", 32'(rv1), 32'(k >= c_lat + 2));
            chk("t_av4", 32'(av4), 32'(k >= c_lat + 1 && k <= c_lat + 4));
            chk("t_rv4", 32'(rv4), 32'(k >= c_lat + 5));
            if (k >= c_lat + 1) begin
                chk("t_a4", 32'(a4), 32'(3'b101));
                chk("t_b4", 32'(b4), 32'(bv));
                chk("t_op4", 32'(op4), 32'(OP_EQ));
            end
        end
        btn_next = 1'b0;
        cyc(c_idle);
        model_step(1'b1, 1'b0);
        check_all("timed");
        chk("t_res1", 32'(res1), 32'(exp_res));
        chk("t_res4", 32'(res4), 32'(exp_res));
        act(1'b1, 1'b0, c_deb + 2);
        check_all("show_to_a");
    endtask

    initial begin
        model_reset();
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        check_all("reset");

        timed_run(3'b101, 4'b0001);
        timed_run(3'b100, 4'b0000);

        // Long hold yields a single advance
        sw = 3'd6;
        act(1'b1, 1'b0, 100 + c_deb);
        check_all("hold100");

        // Simultaneous clear and next in LOAD_B
        sw = 3'd3;
        act(1'b1, 1'b1, c_deb + 2);
        check_all("clr_next");
        chk("cn_a1", 32'(a1), 32'd0);
        chk("cn_b1", 32'(b1), 32'd0);

        // Asynchronous reset in the middle of EXEC
        sw = 3'd2; act(1'b1, 1'b0, c_deb + 2);
        sw = 3'd7; act(1'b1, 1'b0, c_deb + 2);
        sw = OP_ADD;
        btn_next = 1'b1;
        cyc(c_lat + 2);
        chk("mid_exec_av4", 32'(av4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_led4", 32'(led4), 32'd0);
        chk("ar_av4", 32'(av4), 32'd0);
        chk("ar_rv4", 32'(rv4), 32'd0);
        chk("ar_a4", 32'(a4), 32'd0);
        chk("ar_b4", 32'(b4), 32'd0);
        chk("ar_op4", 32'(op4), 32'd0);
        chk("ar_res1", 32'(res1), 32'd0);
        chk("ar_led1", 32'(led1), 32'd0);
        btn_next = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(c_deb + 5);
        model_reset();
        check_all("after_areset");

`ifdef ALU_SEQ_DEBOUNCE_EN
        btn_next = 1'b1;
        cyc(5);
        btn_next = 1'b0;
        cyc(20);
        check_all("glitch");
        sw = 3'd5;
        act(1'b1, 1'b0, 10);
        check_all("press10");
`endif

        for (int i = 0; i < 60; i++) begin
            int r;
            bit nxt, clr;
            sw  = 3'($urandom);
            r   = int'($urandom_range(0, 99));
            clr = (r >= 85);
            nxt = (r < 85) || (r >= 95);
            act(nxt, clr, c_deb + int'($urandom_range(1, 15)));
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
